// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM download splitter.
package jtframe_dwnld_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        SETTLE
    } state_t;

    // Active-low byte-lane masks: MASK_LO writes the low byte, MASK_HI the high byte.
    localparam logic [1:0] MASK_LO = 2'b10;
    localparam logic [1:0] MASK_HI = 2'b01;

    typedef logic [22:0] baddr_t;

    // One SDRAM byte write as held in the output or skid register.
    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } wr_t;

endpackage

// File: rtl/jtframe_dwnld_skid.sv
// Output register plus one-entry skid buffer for SDRAM byte writes.
// A write is held on prog_* until prog_ack; one extra write can wait in the skid.
module jtframe_dwnld_skid
    import jtframe_dwnld_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [21:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic [1:0]  in_mask,
    input  logic        prog_ack,
    input  logic        clr_ovf,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        overflow,
    output logic        idle_next
);

    wr_t in_wr, out_wr, skid_wr;
    logic skid_full;

    assign in_wr     = '{addr: in_addr, data: in_data, mask: in_mask};
    assign prog_addr = out_wr.addr;
    assign prog_data = out_wr.data;
    assign prog_mask = out_wr.mask;

    // Nothing will be pending next cycle: lets the FSM leave DRAIN on the same
    // edge that prog_we drops, so the settle period starts exactly there.
    assign idle_next = !in_valid && !skid_full && (!prog_we || prog_ack);

    // Output/skid handshake; skid is only ever full while prog_we is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr    <= '0;
            skid_wr   <= '0;
            skid_full <= 1'b0;
            prog_we   <= 1'b0;
        end else if (!prog_we) begin
            if (in_valid) begin
                out_wr  <= in_wr;
                prog_we <= 1'b1;
            end
        end else if (prog_ack) begin
            if (skid_full) begin
                out_wr <= skid_wr;
                if (in_valid) skid_wr   <= in_wr;
                else          skid_full <= 1'b0;
            end else if (in_valid) begin
                out_wr <= in_wr;
            end else begin
                prog_we <= 1'b0;
            end
        end else if (in_valid && !skid_full) begin
            skid_wr   <= in_wr;
            skid_full <= 1'b1;
        end
    end

    // Sticky lost-byte flag; a loss in the clearing cycle still wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (in_valid && prog_we && !prog_ack && skid_full)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

endmodule

// File: rtl/jtframe_dwnld.sv
// ROM download splitter: strips the file header, routes bytes to SDRAM
// byte-lane writes or PROM strobes, and keeps dwnld_busy up until drained.
//
// state  | meaning
// IDLE   | no download, nothing pending
// LOAD   | download in progress
// DRAIN  | download ended, SDRAM writes still pending
// SETTLE | all written, holding busy for STRETCH cycles
module jtframe_dwnld
    import jtframe_dwnld_pkg::*;
#(
    parameter int unsigned  HEADER     = 0,
    parameter logic [22:0]  PROM_START = 23'h7F_FFFF,
    parameter int           PROM_AW    = 10,
    parameter int           SWAB       = 0,
    parameter int           STRETCH    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,
    input  logic [22:0]        ioctl_addr,
    input  logic [7:0]         ioctl_data,
    input  logic               ioctl_wr,
    output logic [21:0]        prog_addr,
    output logic [7:0]         prog_data,
    output logic [1:0]         prog_mask,
    output logic               prog_we,
    input  logic               prog_ack,
    output logic               prom_we,
    output logic [PROM_AW-1:0] prom_addr,
    output logic [7:0]         prom_data,
    output logic               dwnld_busy,
    output logic               overflow
);

    localparam logic [23:0] HDR    = 24'(HEADER);
    localparam logic        SWAB_B = (SWAB != 0);
    localparam int          CW     = (STRETCH > 1) ? $clog2(STRETCH) : 1;

    // One extra bit on the subtraction: its borrow marks header bytes.
    logic [23:0]        eff_ext;
    baddr_t             eff;
    logic               hdr_drop, is_prom, prom_hit, sd_hit, lane, dl_q, idle_next;
    logic [1:0]         sd_mask;
    logic [PROM_AW-1:0] prom_nx;
    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;

    assign eff_ext  = {1'b0, ioctl_addr} - HDR;
    assign eff      = eff_ext[22:0];
    assign hdr_drop = eff_ext[23];
    assign is_prom  = eff >= PROM_START;
    assign prom_hit = ioctl_wr && !hdr_drop && is_prom;
    assign sd_hit   = ioctl_wr && !hdr_drop && !is_prom;
    assign lane     = eff[0] ^ SWAB_B;
    assign sd_mask  = lane ? MASK_HI : MASK_LO;
    assign prom_nx  = PROM_AW'(eff - PROM_START);

    jtframe_dwnld_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sd_hit),
        .in_addr   (eff[22:1]),
        .in_data   (ioctl_data),
        .in_mask   (sd_mask),
        .prog_ack  (prog_ack),
        .clr_ovf   (downloading && !dl_q),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_mask (prog_mask),
        .prog_we   (prog_we),
        .overflow  (overflow),
        .idle_next (idle_next)
    );

    // Single-cycle PROM strobe, independent of the SDRAM handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prom_we   <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
        end else begin
            prom_we <= prom_hit;
            if (prom_hit) begin
                prom_addr <= prom_nx;
                prom_data <= ioctl_data;
            end
        end
    end

    // State register, stretch counter and downloading edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dl_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dl_q  <= downloading;
        end
    end

    // Next-state logic; a new download always returns to LOAD with writes kept.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:   if (downloading) state_nx = LOAD;
            LOAD:   if (!downloading) state_nx = DRAIN;
            DRAIN: begin
                if (downloading) begin
                    state_nx = LOAD;
                end else if (idle_next) begin
                    state_nx = SETTLE;
                    cnt_nx   = CW'(STRETCH - 1);
                end
            end
            SETTLE: begin
                if (downloading)   state_nx = LOAD;
                else if (cnt == '0) state_nx = IDLE;
                else               cnt_nx   = cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign dwnld_busy = (state != IDLE);

endmodule

// File: tb/tb_jtframe_dwnld.sv
// Scoreboard bench for jtframe_dwnld (HEADER=2, PROM_START=0x100, STRETCH=4);
// a second instance with SWAB=1 shares all inputs.
module tb_jtframe_dwnld;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [22:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_ack = 1'b0;

    logic [21:0] prog_addr, b_prog_addr;
    logic [7:0]  prog_data, b_prog_data, prom_data, b_prom_data;
    logic [1:0]  prog_mask, b_prog_mask;
    logic        prog_we, b_prog_we, prom_we, b_prom_we;
    logic [9:0]  prom_addr, b_prom_addr;
    logic        dwnld_busy, b_dwnld_busy, overflow, b_overflow;

    jtframe_dwnld #(.HEADER(2), .PROM_START(23'h100), .PROM_AW(10), .SWAB(0), .STRETCH(4)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
        .prog_ack(prog_ack), .prom_we(prom_we), .prom_addr(prom_addr),
        .prom_data(prom_data), .dwnld_busy(dwnld_busy), .overflow(overflow)
    );

    jtframe_dwnld #(.HEADER(2), .PROM_START(23'h100), .PROM_AW(10), .SWAB(1), .STRETCH(4)) dut_swab (
        .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(b_prog_addr),
        .prog_data(b_prog_data), .prog_mask(b_prog_mask), .prog_we(b_prog_we),
        .prog_ack(prog_ack), .prom_we(b_prom_we), .prom_addr(b_prom_addr),
        .prom_data(b_prom_data), .dwnld_busy(b_dwnld_busy), .overflow(b_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   ack_en   = 1'b0;
    int   ack_dly  = 1;
    int   wcnt     = 0;

    // Automatic SDRAM responder: acks ack_dly cycles after prog_we is seen.
    always @(posedge clk) begin
        #1;
        if (ack_en) begin
            if (prog_we && !prog_ack) begin
                if (wcnt >= ack_dly) begin
                    prog_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                prog_ack = 1'b0;
            end
        end
    end

    // Scoreboard: every accepted SDRAM write must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && prog_we && prog_ack) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sdram_write unexpected: got addr=%h mask=%b data=%h, required none",
                         prog_addr, prog_mask, prog_data);
            end else begin
                e = sb.pop_front();
                if ({prog_addr, prog_mask, prog_data} !== {e.addr, e.mask, e.data}) begin
                    n_fail++;
                    $display("FAIL sdram_write: got addr=%h mask=%b data=%h, required addr=%h mask=%b data=%h",
                             prog_addr, prog_mask, prog_data, e.addr, e.mask, e.data);
                end
            end
        end
    end

    // Reference decode for the SWAB=0 instance.
    function automatic void expect_byte(input logic [22:0] a, input logic [7:0] d);
        logic [22:0] eff;
        exp_t e;
        eff = a - 23'd2;
        if (a >= 23'd2 && eff < 23'h100) begin
            e.addr = eff[22:1];
            e.mask = eff[0] ? 2'b01 : 2'b10;
            e.data = d;
            sb.push_back(e);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one ioctl_wr pulse; returns 1 time unit after the sampling edge.
    task automatic send(input logic [22:0] a, input logic [7:0] d, input bit push);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        if (push) expect_byte(a, d);
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int i;
        i = 0;
        while ((sb.size() != 0 || prog_we) && i < 100) begin
            tick(1);
            i++;
        end
        ok = (sb.size() == 0) && !prog_we;
    endtask

    task automatic stop_ack();
        ack_en   = 1'b0;
        prog_ack = 1'b0;
        wcnt     = 0;
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++;
        if ({prog_we, prom_we, dwnld_busy, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got we=%b prom_we=%b busy=%b ovf=%b, required all 0",
                     prog_we, prom_we, dwnld_busy, overflow);
        end
        n_checks++;
        if ({prog_addr, prog_data, prog_mask} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_prog_bus: got addr=%h data=%h mask=%b, required 0", prog_addr, prog_data, prog_mask);
        end
        n_checks++;
        if ({prom_addr, prom_data} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_prom_bus: got addr=%h data=%h, required 0", prom_addr, prom_data);
        end
        rst = 1'b0;
        tick(2);
        n_checks++;
        if (dwnld_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b, required 0", dwnld_busy);
        end
    endtask

    task automatic test_mapping();
        bit ok;
        downloading = 1'b1;
        n_checks++;
        if (dwnld_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_early: got %b, required 0", dwnld_busy);
        end
        tick(1);
        n_checks++;
        if (dwnld_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: got %b, required 1", dwnld_busy);
        end
        ack_en  = 1'b1;
        ack_dly = 1;
        for (int i = 0; i < 6; i++) begin
            send(23'(i), 8'h10 + 8'(i), 1'b1);
            tick(3);
        end
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL mapping_drain: got %0d pending, required 0", sb.size());
        end
        stop_ack();
    endtask

    task automatic test_skid();
        bit ok, stable;
        send(23'd12, 8'hC1, 1'b1);
        send(23'd13, 8'hC2, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!(prog_we === 1'b1 && prog_data === 8'hC1 && prog_addr === 22'd5 &&
                  prog_mask === 2'b10 && overflow === 1'b0)) stable = 1'b0;
            tick(1);
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_hold: got we=%b data=%h addr=%h ovf=%b, required 1 C1 5 0 throughout",
                     prog_we, prog_data, prog_addr, overflow);
        end
        send(23'd14, 8'hC3, 1'b0);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_overflow: got %b, required 1", overflow);
        end
        ack_en = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_drain: got %0d pending, required 0", sb.size());
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b, required 1", overflow);
        end
        stop_ack();
    endtask

    task automatic test_prom();
        bit seen_we;
        send(23'h107, 8'hA5, 1'b1);
        n_checks++;
        if ({prom_we, prom_addr, prom_data} !== {1'b1, 10'd5, 8'hA5}) begin
            n_fail++;
            $display("FAIL prom_write: got we=%b addr=%h data=%h, required 1 005 a5", prom_we, prom_addr, prom_data);
        end
        seen_we = prog_we;
        tick(1);
        n_checks++;
        if (prom_we !== 1'b0) begin
            n_fail++;
            $display("FAIL prom_pulse_width: got %b, required 0", prom_we);
        end
        for (int i = 0; i < 5; i++) begin
            seen_we |= prog_we;
            tick(1);
        end
        n_checks++;
        if (seen_we !== 1'b0) begin
            n_fail++;
            $display("FAIL prom_no_sdram: got prog_we seen=%b, required 0", seen_we);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        downloading = 1'b0;
        tick(1);
        downloading = 1'b1;
        tick(1);
        n_checks++;
        if ({overflow, b_overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b%b, required 00", overflow, b_overflow);
        end
        send(23'd22, 8'hD1, 1'b1);
        send(23'd23, 8'hD2, 1'b1);
        n_checks++;
        if ({prog_mask, b_prog_mask, b_prog_data} !== {2'b10, 2'b01, 8'hD1}) begin
            n_fail++;
            $display("FAIL swab_even: got mask=%b swab_mask=%b swab_data=%h, required 10 01 d1",
                     prog_mask, b_prog_mask, b_prog_data);
        end
        prog_ack = 1'b1;
        send(23'd24, 8'hD3, 1'b1);
        prog_ack = 1'b0;
        n_checks++;
        if ({overflow, b_overflow, prog_we, prog_data} !== {3'b001, 8'hD2}) begin
            n_fail++;
            $display("FAIL simul_ack_wr: got ovf=%b/%b we=%b data=%h, required 0/0 1 d2",
                     overflow, b_overflow, prog_we, prog_data);
        end
        n_checks++;
        if ({b_prog_mask, b_prog_data} !== {2'b10, 8'hD2}) begin
            n_fail++;
            $display("FAIL swab_odd: got mask=%b data=%h, required 10 d2", b_prog_mask, b_prog_data);
        end
        prog_ack = 1'b1;
        tick(1);
        prog_ack = 1'b0;
        n_checks++;
        if ({b_prog_mask, b_prog_data} !== {2'b01, 8'hD3}) begin
            n_fail++;
            $display("FAIL swab_skid_even: got mask=%b data=%h, required 01 d3", b_prog_mask, b_prog_data);
        end
        ack_en = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_drain: got %0d pending, required 0", sb.size());
        end
        stop_ack();
    endtask

    task automatic test_stretch();
        int cnt;
        send(23'd30, 8'hE1, 1'b1);
        downloading = 1'b0;
        tick(3);
        n_checks++;
        if ({dwnld_busy, prog_we} !== 2'b11) begin
            n_fail++;
            $display("FAIL drain_hold: got busy=%b we=%b, required 1 1", dwnld_busy, prog_we);
        end
        prog_ack = 1'b1;
        tick(1);
        prog_ack = 1'b0;
        n_checks++;
        if (prog_we !== 1'b0) begin
            n_fail++;
            $display("FAIL stretch_we_fall: got %b, required 0", prog_we);
        end
        cnt = 0;
        while (dwnld_busy && cnt < 20) begin
            cnt++;
            tick(1);
        end
        n_checks++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL stretch_len: got %0d cycles, required 4", cnt);
        end
    endtask

    task automatic test_reset_mid();
        downloading = 1'b1;
        tick(1);
        send(23'd40, 8'hF1, 1'b0);
        n_checks++;
        if ({dwnld_busy, prog_we} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset: got busy=%b we=%b, required 1 1", dwnld_busy, prog_we);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({prog_we, dwnld_busy, prog_data, prog_mask} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: got we=%b busy=%b data=%h mask=%b, required 0",
                     prog_we, dwnld_busy, prog_data, prog_mask);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        n_checks++;
        if ({dwnld_busy, prog_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset: got busy=%b we=%b, required 1 0", dwnld_busy, prog_we);
        end
        downloading = 1'b0;
        tick(10);
        n_checks++;
        if (sb.size() != 0 || dwnld_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL final: got %0d pending busy=%b, required 0 0", sb.size(), dwnld_busy);
        end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_skid();
        test_prom();
        test_simultaneous();
        test_stretch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
